// File: rtl/lamp_stretch.sv
// Per-channel lamp pulse stretcher with a shared tick prescaler.
// Each lamp stays on for a minimum hold time and then stays off for a minimum gap.
module lamp_stretch #(
   parameter int WIDTH = 1,
   parameter int RATE  = 125000,
   parameter int HOLD  = 3,
   parameter int GAP   = 1
) (
   input  logic             clk,
   input  logic             rst,
   input  logic [WIDTH-1:0] events,
   output logic [WIDTH-1:0] lamps,
   output logic             any_on
);

   localparam logic [23:0] RATE_C = 24'(RATE);
   localparam logic [7:0]  HOLD_C = 8'(HOLD);
   localparam logic [7:0]  GAP_C  = 8'(GAP);

   typedef enum logic [1:0] {
      S_IDLE,
      S_ON,
      S_GAP
   } state_t;

   logic [23:0]      pre;
   logic             tick;
   logic [WIDTH-1:0] lamp_next;

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         pre <= '0;
      end else if (pre == RATE_C) begin
         pre <= '0;
      end else begin
         pre <= pre + 24'd1;
      end
   end

   assign tick = (pre == 24'd0);

   for (genvar i = 0; i < WIDTH; i++) begin : g_ch
      state_t     st, st_n;
      logic [7:0] cnt, cnt_n;
      logic       pend, pend_n;

      always_ff @(posedge clk or posedge rst) begin
         if (rst) begin
            st   <= S_IDLE;
            cnt  <= '0;
            pend <= 1'b0;
         end else begin
            st   <= st_n;
            cnt  <= cnt_n;
            pend <= pend_n;
         end
      end

      // An event in the same cycle as the expiry tick retriggers instead.
      always_comb begin
         st_n   = st;
         cnt_n  = cnt;
         pend_n = pend;
         unique case (st)
            S_IDLE: begin
               if (events[i]) begin
                  st_n  = S_ON;
                  cnt_n = HOLD_C;
               end
            end
            S_ON: begin
               if (events[i]) begin
                  cnt_n = HOLD_C;
               end else if (tick) begin
                  if (cnt == 8'd1) begin
                     if (GAP == 0) begin
                        st_n  = S_IDLE;
                        cnt_n = '0;
                     end else begin
                        st_n  = S_GAP;
                        cnt_n = GAP_C;
                     end
                  end else begin
                     cnt_n = cnt - 8'd1;
                  end
               end
            end
            S_GAP: begin
               if (events[i]) begin
                  pend_n = 1'b1;
               end
               if (tick) begin
                  if (cnt == 8'd1) begin
                     pend_n = 1'b0;
                     if (pend || events[i]) begin
                        st_n  = S_ON;
                        cnt_n = HOLD_C;
                     end else begin
                        st_n  = S_IDLE;
                        cnt_n = '0;
                     end
                  end else begin
                     cnt_n = cnt - 8'd1;
                  end
               end
            end
            default: begin
               st_n   = S_IDLE;
               cnt_n  = '0;
               pend_n = 1'b0;
            end
         endcase
      end

      assign lamp_next[i] = (st_n == S_ON);
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         lamps  <= '0;
         any_on <= 1'b0;
      end else begin
         lamps  <= lamp_next;
         any_on <= |lamp_next;
      end
   end

endmodule

// File: tb/tb_lamp_stretch.sv
// Bench for lamp_stretch: GAP=1 and GAP=0 builds share one stimulus stream
// and are checked every cycle against a tick-deadline model.
module tb_lamp_stretch;

   localparam int RATE = 3;
   localparam int HOLD = 2;

   logic       clk = 1'b0;
   logic       rst = 1'b1;
   logic [1:0] events = 2'b00;
   logic [1:0] lamps1, lamps0;
   logic       any1, any0;
   bit         chk_en = 1'b0;

   int n_chk = 0;
   int n_fail = 0;

   always #5 clk = ~clk;

   lamp_stretch #(.WIDTH(2), .RATE(RATE), .HOLD(HOLD), .GAP(1)) dut (
      .clk(clk), .rst(rst), .events(events),
      .lamps(lamps1), .any_on(any1)
   );

   lamp_stretch #(.WIDTH(2), .RATE(RATE), .HOLD(HOLD), .GAP(0)) dut0 (
      .clk(clk), .rst(rst), .events(events),
      .lamps(lamps0), .any_on(any0)
   );

   // Model: lamp lit until the HOLD-th tick after the latest event,
   // then dark until the GAP-th tick after expiry. Index k: 0=GAP1, 1=GAP0.
   int cyc = 0;
   int tcount = 0;
   bit tk;
   int tnow;
   bit e;
   int gp;
   bit m_lit[2][2];
   bit m_gap[2][2];
   bit m_pend[2][2];
   int m_dl[2][2];
   int m_ge[2][2];

   always @(posedge clk or posedge rst) begin
      if (rst) begin
         cyc = 0;
         tcount = 0;
         for (int k = 0; k < 2; k++)
            for (int c = 0; c < 2; c++) begin
               m_lit[k][c] = 0;
               m_gap[k][c] = 0;
               m_pend[k][c] = 0;
            end
      end else begin
         tk = (cyc % (RATE + 1)) == 0;
         tnow = tcount + (tk ? 1 : 0);
         for (int k = 0; k < 2; k++)
            for (int c = 0; c < 2; c++) begin
               e = events[c];
               gp = (k == 0) ? 1 : 0;
               if (m_lit[k][c]) begin
                  if (e) begin
                     m_dl[k][c] = tnow + HOLD;
                  end else if (tk && tnow == m_dl[k][c]) begin
                     m_lit[k][c] = 0;
                     if (gp > 0) begin
                        m_gap[k][c] = 1;
                        m_ge[k][c] = tnow + gp;
                        m_pend[k][c] = 0;
                     end
                  end
               end else if (m_gap[k][c]) begin
                  if (tk && tnow == m_ge[k][c]) begin
                     if (m_pend[k][c] || e) begin
                        m_lit[k][c] = 1;
                        m_dl[k][c] = tnow + HOLD;
                     end
                     m_gap[k][c] = 0;
                     m_pend[k][c] = 0;
                  end else if (e) begin
                     m_pend[k][c] = 1;
                  end
               end else if (e) begin
                  m_lit[k][c] = 1;
                  m_dl[k][c] = tnow + HOLD;
               end
            end
         tcount = tnow;
         cyc++;
      end
   end

   task automatic chk(input string nm, input logic [1:0] act,
                      input logic [1:0] exp);
      n_chk++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: got %b expected %b at %0t", nm, act, exp, $time);
      end
   endtask

   task automatic chk_rng(input string nm, input int act,
                          input int lo, input int hi);
      n_chk++;
      if (act < lo || act > hi) begin
         n_fail++;
         $display("FAIL %s: got %0d expected %0d..%0d at %0t",
                  nm, act, lo, hi, $time);
      end
   endtask

   always @(negedge clk) begin
      if (!rst && chk_en) begin
         chk("model_lamps_gap1", lamps1, {m_lit[0][1], m_lit[0][0]});
         chk("model_any_gap1", {1'b0, any1},
             {1'b0, m_lit[0][1] | m_lit[0][0]});
         chk("model_lamps_gap0", lamps0, {m_lit[1][1], m_lit[1][0]});
         chk("model_any_gap0", {1'b0, any0},
             {1'b0, m_lit[1][1] | m_lit[1][0]});
      end
   end

   function automatic logic lampsel(input int w);
      case (w)
         0: return lamps1[0];
         1: return lamps1[1];
         2: return lamps0[0];
         default: return lamps0[1];
      endcase
   endfunction

   task automatic measure(input int w, input logic lvl, output int n);
      n = 0;
      while (lampsel(w) === lvl && n < 40) begin
         n++;
         @(negedge clk);
      end
      if (n >= 40) begin
         n_chk++;
         n_fail++;
         $display("FAIL wait_timeout: lamp %0d stuck at %b", w, lvl);
      end
   endtask

   int n;
   int dens;

   initial begin
      repeat (3) @(negedge clk);
      chk("reset_lamps", lamps1, 2'b00);
      chk("reset_any", {1'b0, any1}, 2'b00);
      chk("reset_lamps_gap0", lamps0, 2'b00);
      rst = 1'b0;
      chk_en = 1'b1;

      @(negedge clk);
      events = 2'b01;
      @(negedge clk);
      events = 2'b00;
      chk("rise_one_cycle", lamps1, 2'b01);
      chk("rise_any", {1'b0, any1}, 2'b01);
      measure(0, 1'b1, n);
      chk_rng("isolated_len", n, 5, 8);

      // Event one cycle after expiry: GAP=0 relights, GAP=1 defers.
      events = 2'b01;
      @(negedge clk);
      events = 2'b00;
      chk("gap0_relight", {1'b0, lamps0[0]}, 2'b01);
      chk("gap_stays_dark", {1'b0, lamps1[0]}, 2'b00);
      measure(0, 1'b0, n);
      chk_rng("gap_low_rest", n, 3, 3);
      measure(0, 1'b1, n);
      chk_rng("gap_relight_len", n, 8, 8);

      repeat (20) @(negedge clk);
      for (int i = 0; i < 7; i++) begin
         events = 2'b01;
         @(negedge clk);
         events = 2'b00;
         chk("retrig_a", {1'b0, lamps1[0]}, 2'b01);
         @(negedge clk);
         chk("retrig_b", {1'b0, lamps1[0]}, 2'b01);
         @(negedge clk);
         chk("retrig_c", {1'b0, lamps1[0]}, 2'b01);
      end
      events = 2'b01;
      @(negedge clk);
      events = 2'b00;
      measure(0, 1'b1, n);
      chk_rng("retrig_tail_len", n, 5, 8);

      repeat (20) @(negedge clk);
      events = 2'b11;
      @(negedge clk);
      for (int i = 0; i < 30; i++) begin
         chk("continuous", lamps1, 2'b11);
         @(negedge clk);
      end
      events = 2'b00;

      repeat (20) @(negedge clk);
      events = 2'b10;
      @(negedge clk);
      events = 2'b00;
      measure(1, 1'b1, n);
      events = 2'b11;
      @(negedge clk);
      events = 2'b00;
      chk("pre_reset_state", lamps1, 2'b01);
      #2 rst = 1'b1;
      #1 chk("reset_async_lamps", lamps1, 2'b00);
      chk("reset_async_any", {1'b0, any1}, 2'b00);
      @(negedge clk);
      #1 rst = 1'b0;
      for (int i = 0; i < 20; i++) begin
         @(negedge clk);
         chk("no_relight", lamps1, 2'b00);
      end

      // Retrigger on the exact expiry tick, known from the reset phase.
      #1 rst = 1'b1;
      #1 rst = 1'b0;
      events = 2'b01;
      @(negedge clk);
      events = 2'b00;
      for (int i = 0; i < 7; i++) begin
         chk("coincident_on", {1'b0, lamps1[0]}, 2'b01);
         @(negedge clk);
      end
      events = 2'b01;
      @(negedge clk);
      events = 2'b00;
      measure(0, 1'b1, n);
      chk_rng("coincident_len", n, 8, 8);

      for (int i = 0; i < 4000; i++) begin
         @(negedge clk);
         if (i % 500 == 0) dens = $urandom_range(2, 60);
         events[0] = $urandom_range(0, 99) < dens;
         events[1] = $urandom_range(0, 99) < dens;
         if ($urandom_range(0, 999) == 0) begin
            #2 rst = 1'b1;
            #1 chk("rand_reset", lamps1 | lamps0, 2'b00);
            rst = 1'b0;
         end
      end
      events = 2'b00;
      repeat (4) @(negedge clk);

      $display("End of test - %0d assertions evaluated, %0d failures",
               n_chk, n_fail);
      $finish;
   end

   initial begin
      #1000000;
      $display("FAIL watchdog: simulation did not finish");
      $fatal(1);
   end

endmodule

// File: doc/lamp_stretch.md
LAMP_STRETCH -- requirements
Module: lamp_stretch

Interface
REQ-001 SHALL have parameter WIDTH, default 1: number of independent lamp channels.
REQ-002 SHALL have parameter RATE, default 125000: prescaler terminal count; tick period is RATE+1 clk cycles; legal range 1..2^24-1.
REQ-003 SHALL have parameter HOLD, default 3: minimum lamp-on time in ticks; legal range 1..255.
REQ-004 SHALL have parameter GAP, default 1: minimum lamp-off time in ticks after expiry; legal range 0..255.
REQ-005 SHALL have port clk  input  1  clock; all state is updated on its rising edge.
REQ-006 SHALL have port rst  input  1  asynchronous, active-high reset.
REQ-007 SHALL have port events  input  WIDTH  per-channel internal event strobes; synchronous to clk; any width from 1 cycle upward.
REQ-008 SHALL have port lamps  output  WIDTH  registered per-channel lamp drive toward the external indicator/LED pins.
REQ-009 SHALL have port any_on  output  1  registered OR of all lamp bits, updated in the same cycle as lamps.

Function
REQ-010 SHALL hold a shared 24-bit prescaler counting 0..RATE and wrapping to 0; tick SHALL be asserted in every cycle where the counter equals 0.
REQ-011 SHALL give each channel its own FSM with states IDLE, ON and GAP, an 8-bit down-counter and a pending flag.
REQ-012 SHALL sample events on every clk cycle, not only on tick cycles.
REQ-013 IDLE: on event=1, SHALL go to ON next cycle, with lamp=1 and counter=HOLD; lamp rises exactly 1 cycle after the event cycle.
REQ-014 ON: on tick, SHALL decrement the counter; event=1 in any ON cycle SHALL reload the counter with HOLD (retrigger).
REQ-015 ON, tick with counter=1 and event=0: SHALL drop lamp=0 next cycle and go to GAP with counter=GAP, or to IDLE if GAP=0.
REQ-016 ON, tick with counter=1 and event=1 in the same cycle: retrigger SHALL win; the channel stays ON with counter=HOLD.
REQ-017 GAP: lamp SHALL stay 0; event=1 SHALL set pending; tick SHALL decrement the counter.
REQ-018 GAP, tick with counter=1: if pending=1 or event=1, SHALL go to ON with lamp=1 and counter=HOLD; otherwise SHALL go to IDLE; pending SHALL clear in both cases.
REQ-019 Lamp-on duration for an isolated 1-cycle event SHALL be within (HOLD-1)*(RATE+1)+1 .. HOLD*(RATE+1) clk cycles.
REQ-020 Channels SHALL be fully independent; only the prescaler is shared.
REQ-021 Counter arithmetic SHALL never wrap below 0; counter=0 SHALL occur only in IDLE.
REQ-022 Continuous event=1 SHALL hold the lamp on indefinitely with no gap.

Reset
REQ-023 rst=1 SHALL asynchronously set the prescaler to 0, every channel to IDLE with counter=0 and pending=0, and lamps=0 and any_on=0.
REQ-024 rst asserted mid-ON or mid-GAP SHALL force lamps=0 immediately; no pending event survives reset.
REQ-025 After rst deasserts, the first clk cycle SHALL be a tick cycle (prescaler=0).

Verification
All scenarios use RATE=3 (tick every 4 clocks), HOLD=2, GAP=1, WIDTH=2.
REQ-026 1-cycle event on ch0 -> lamps[0]=1 one cycle later; lamps[0]=0 after 5..8 cycles; any_on follows; lamps[1] stays 0.
REQ-027 Second event on ch0 every 3 cycles for 20 cycles -> lamps[0] stays 1 throughout and drops 5..8 cycles after the last event.
REQ-028 Event during GAP -> lamp stays 0 until the gap tick, then 1 for a full HOLD; pending clears.
REQ-029 Event coincident with the expiry tick (counter=1) -> no 0 glitch on lamps[0].
REQ-030 rst pulse while ch0 is ON and ch1 is in GAP with pending=1 -> both lamps 0 at once; no re-light after reset without a new event.
REQ-031 GAP=0 build, event at expiry+1 cycle -> lamp low for exactly 1 cycle, then high again.
